// File: rtl/xswitch_pkg.sv
// Shared types and helpers for the NxM FIFO crossbar switch.
package xswitch_pkg;

    typedef enum logic [1:0] {
        ST_RESET  = 2'd0,
        ST_INIT   = 2'd1,
        ST_IDLE   = 2'd2,
        ST_ACTIVE = 2'd3
    } state_e;

    localparam int DEFAULT_LOW = 2;

    function automatic int defaultHigh(input int depth);
        return depth - 2;
    endfunction

    // Destination lives in the top destW bits of a w-bit word.
    function automatic int destOf(input logic [63:0] word, input int w, input int destW);
        return int'((word >> (w - destW)) & ((64'd1 << destW) - 64'd1));
    endfunction

endpackage

// File: rtl/xfifo_p.sv
// Parametrised FIFO with either fall-through head or registered pop data,
// plus sticky overflow/underflow flags and a look-ahead count.
module xfifo_p #(
    parameter int W     = 10,
    parameter int DEPTH = 8,
    parameter bit FWFT  = 1'b1,
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [W-1:0]     data_i,
    output logic [W-1:0]     data_o,
    output logic [CNT_W-1:0] count_o,
    output logic [CNT_W-1:0] countNext_o,
    output logic             full_o,
    output logic             empty_o,
    output logic             ovf_o,
    output logic             udf_o
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]     mem_q [DEPTH];
    logic [AW-1:0]    rdPtr_q, wrPtr_q;
    logic [CNT_W-1:0] count_q, count_d;
    logic             ovf_q, udf_q;
    logic             doPush, doPop;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign doPop   = pop_i && !empty_o && !flush_i;
    // A full FIFO still accepts a word when it is being popped in the same cycle.
    assign doPush  = push_i && !flush_i && (!full_o || doPop);

    always_comb begin
        count_d = count_q + CNT_W'(doPush) - CNT_W'(doPop);
        if (flush_i) begin
            count_d = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            rdPtr_q <= '0;
            wrPtr_q <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            if (flush_i) begin
                rdPtr_q <= '0;
                wrPtr_q <= '0;
            end else begin
                if (doPush) wrPtr_q <= wrPtr_q + AW'(1);
                if (doPop)  rdPtr_q <= rdPtr_q + AW'(1);
                if (push_i && !doPush) ovf_q <= 1'b1;
                if (pop_i && empty_o)  udf_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (doPush) begin
            mem_q[wrPtr_q] <= data_i;
        end
    end

    if (FWFT) begin : g_fwft
        assign data_o = mem_q[rdPtr_q];
    end else begin : g_reg
        logic [W-1:0] dout_q;
        always_ff @(posedge clk_i) begin
            if (!rst_ni) begin
                dout_q <= '0;
            end else if (doPop) begin
                dout_q <= mem_q[rdPtr_q];
            end
        end
        assign data_o = dout_q;
    end

    assign count_o     = count_q;
    assign countNext_o = count_d;
    assign ovf_o       = ovf_q;
    assign udf_o       = udf_q;

endmodule

// File: rtl/xswitch_nxm.sv
// NUM_IN x NUM_OUT FIFO switch: round-robin arbiter over a single shared
// transfer path, per-output hysteresis backpressure, push counters, sticky errors.
module xswitch_nxm
    import xswitch_pkg::*;
#(
    parameter int NUM_IN  = 4,
    parameter int NUM_OUT = 4,
    parameter int W       = 10,
    parameter int DEPTH   = 8,
    parameter int CTR_W   = 7,
    localparam int DEST_W = $clog2(NUM_OUT),
    localparam int CNT_W  = $clog2(DEPTH) + 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_IN*W-1:0]       in_data,
    input  logic [NUM_IN-1:0]         push,
    output logic [NUM_IN-1:0]         in_full,
    input  logic [NUM_OUT-1:0]        pop,
    output logic [NUM_OUT*W-1:0]      out_data,
    output logic [NUM_OUT-1:0]        out_empty,
    input  logic [CNT_W-1:0]          high_cfg,
    input  logic [CNT_W-1:0]          low_cfg,
    input  logic                      init,
    output logic                      idle,
    input  logic                      req,
    input  logic [DEST_W-1:0]         idx,
    output logic [CTR_W-1:0]          counter,
    output logic                      valid_counter,
    output logic [NUM_IN+NUM_OUT-1:0] err
);
    localparam int GW = $clog2(NUM_IN);

    state_e                           state_q, state_d;
    logic [CNT_W-1:0]                 high_q, low_q;
    logic [NUM_OUT-1:0]               blk_q, blk_d;
    logic [GW-1:0]                    lastGrant_q;
    logic [CTR_W-1:0]                 ctr_q [NUM_OUT];
    logic [CTR_W-1:0]                 counter_q;
    logic                             validCounter_q;

    logic                             flush, opsEn, anyBusy;
    logic [NUM_IN-1:0][W-1:0]         inHead;
    logic [NUM_IN-1:0][DEST_W-1:0]    headDest;
    logic [NUM_IN-1:0][CNT_W-1:0]     inCnt, inCntNext;
    logic [NUM_IN-1:0]                inEmpty, inOvf, inUdf, inPop, eligible;
    logic [NUM_OUT-1:0][W-1:0]        outWord;
    logic [NUM_OUT-1:0][CNT_W-1:0]    outCnt, outCntNext;
    logic [NUM_OUT-1:0]               outFull, outOvf, outUdf, outPush;
    logic                             grantValid;
    logic [GW-1:0]                    grantIdx, cand;
    logic [DEST_W-1:0]                grantDest;
    logic [W-1:0]                     xferWord;
    logic                             unusedBits;

    assign flush   = (state_q == ST_INIT);
    assign opsEn   = (state_q == ST_IDLE) || (state_q == ST_ACTIVE);
    assign anyBusy = !((&inEmpty) && (&out_empty));

    for (genvar i = 0; i < NUM_IN; i++) begin : g_in
        xfifo_p #(.W(W), .DEPTH(DEPTH), .FWFT(1'b1)) u_fifo (
            .clk_i(clk), .rst_ni(reset), .flush_i(flush),
            .push_i(push[i] && opsEn), .pop_i(inPop[i]),
            .data_i(in_data[i*W +: W]), .data_o(inHead[i]),
            .count_o(inCnt[i]), .countNext_o(inCntNext[i]),
            .full_o(in_full[i]), .empty_o(inEmpty[i]),
            .ovf_o(inOvf[i]), .udf_o(inUdf[i])
        );
        assign headDest[i] = DEST_W'(destOf(64'(inHead[i]), W, DEST_W));
        assign eligible[i] = opsEn && !inEmpty[i] && !blk_q[headDest[i]] && !outFull[headDest[i]];
        assign inPop[i]    = grantValid && (grantIdx == GW'(i));
    end

    for (genvar o = 0; o < NUM_OUT; o++) begin : g_out
        assign outPush[o] = grantValid && (grantDest == DEST_W'(o));
        xfifo_p #(.W(W), .DEPTH(DEPTH), .FWFT(1'b0)) u_fifo (
            .clk_i(clk), .rst_ni(reset), .flush_i(flush),
            .push_i(outPush[o]), .pop_i(pop[o] && opsEn),
            .data_i(xferWord), .data_o(outWord[o]),
            .count_o(outCnt[o]), .countNext_o(outCntNext[o]),
            .full_o(outFull[o]), .empty_o(out_empty[o]),
            .ovf_o(outOvf[o]), .udf_o(outUdf[o])
        );
    end

    // Search starts one past the last winner so every input gets a fair turn.
    always_comb begin
        grantValid = 1'b0;
        grantIdx   = lastGrant_q;
        cand       = '0;
        for (int k = 1; k <= NUM_IN; k++) begin
            cand = GW'((int'(lastGrant_q) + k) % NUM_IN);
            if (!grantValid && eligible[cand]) begin
                grantValid = 1'b1;
                grantIdx   = cand;
            end
        end
    end

    assign grantDest = headDest[grantIdx];
    assign xferWord  = inHead[grantIdx];

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RESET:  state_d = ST_INIT;
            ST_INIT:   if (!init) state_d = ST_IDLE;
            ST_IDLE:   if (anyBusy) state_d = ST_ACTIVE;
            ST_ACTIVE: if (!anyBusy) state_d = ST_IDLE;
            default:   state_d = ST_RESET;
        endcase
        if (init && (state_q != ST_RESET)) begin
            state_d = ST_INIT;
        end
    end

    // Hysteresis looks at the post-edge count so blk tracks what the FIFO will hold.
    always_comb begin
        blk_d = blk_q;
        for (int o = 0; o < NUM_OUT; o++) begin
            if (flush) begin
                blk_d[o] = 1'b0;
            end else if (opsEn) begin
                if (outCntNext[o] >= high_q)     blk_d[o] = 1'b1;
                else if (outCntNext[o] <= low_q) blk_d[o] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q        <= ST_RESET;
            high_q         <= CNT_W'(defaultHigh(DEPTH));
            low_q          <= CNT_W'(DEFAULT_LOW);
            blk_q          <= '0;
            lastGrant_q    <= GW'(NUM_IN - 1);
            counter_q      <= '0;
            validCounter_q <= 1'b0;
            for (int o = 0; o < NUM_OUT; o++) ctr_q[o] <= '0;
        end else begin
            state_q <= state_d;
            blk_q   <= blk_d;
            if (flush) begin
                high_q <= high_cfg;
                low_q  <= (low_cfg >= high_cfg) ? high_cfg - CNT_W'(1) : low_cfg;
            end
            if (grantValid) lastGrant_q <= grantIdx;
            for (int o = 0; o < NUM_OUT; o++) begin
                if (outPush[o]) ctr_q[o] <= ctr_q[o] + CTR_W'(1);
            end
            validCounter_q <= (state_q == ST_IDLE) && req;
            if ((state_q == ST_IDLE) && req) counter_q <= ctr_q[idx];
        end
    end

    assign out_data      = outWord;
    assign idle          = (state_q == ST_IDLE);
    assign counter       = counter_q;
    assign valid_counter = validCounter_q;
    assign err           = {outUdf, inOvf};
    assign unusedBits    = ^{inCnt, inCntNext, inUdf, outCnt, outOvf};

endmodule

// File: tb/tb_xswitch_nxm.sv
// Directed bench for xswitch_nxm with a queue-based reference model checked every cycle.
module tb_xswitch_nxm;
    localparam int NI = 4, NO = 4, W = 10, DEPTH = 8, CTR_W = 7, DW = 2, CW = 4;
    localparam int S_RESET = 0, S_INIT = 1, S_IDLE = 2, S_ACTIVE = 3;

    logic            clk = 1'b0;
    logic            reset;
    logic [NI*W-1:0] in_data;
    logic [NI-1:0]   push;
    logic [NI-1:0]   in_full;
    logic [NO-1:0]   pop;
    logic [NO*W-1:0] out_data;
    logic [NO-1:0]   out_empty;
    logic [CW-1:0]   high_cfg, low_cfg;
    logic            init, idle, req, valid_counter;
    logic [DW-1:0]   idx;
    logic [CTR_W-1:0] counter;
    logic [NI+NO-1:0] err;

    int nVec = 0;
    int nFail = 0;

    // Reference model state: plain queues per FIFO plus a few scalars.
    logic [W-1:0] mIn  [NI][$];
    logic [W-1:0] mOut [NO][$];
    logic [W-1:0] mOutData [NO];
    int           mCtr [NO];
    int           mState, mHigh, mLow, mLast, mCounter;
    bit           mValid, mReady = 0;
    logic [NO-1:0]    mBlk;
    logic [NI+NO-1:0] mErr;

    always #5 clk = ~clk;

    xswitch_nxm #(.NUM_IN(NI), .NUM_OUT(NO), .W(W), .DEPTH(DEPTH), .CTR_W(CTR_W)) dut (
        .clk(clk), .reset(reset), .in_data(in_data), .push(push), .in_full(in_full),
        .pop(pop), .out_data(out_data), .out_empty(out_empty),
        .high_cfg(high_cfg), .low_cfg(low_cfg), .init(init), .idle(idle),
        .req(req), .idx(idx), .counter(counter), .valid_counter(valid_counter), .err(err)
    );

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        nVec++;
        if (actual !== expected) begin
            nFail++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input int cycles);
        repeat (cycles) @(posedge clk);
        #1;
    endtask

    always @(posedge clk) begin : model
        int g, d, c, old;
        int preSize [NI];
        bit anyNE;
        logic [W-1:0] w;
        if (!reset) begin
            for (int i = 0; i < NI; i++) mIn[i].delete();
            for (int o = 0; o < NO; o++) begin
                mOut[o].delete();
                mOutData[o] = '0;
                mCtr[o] = 0;
            end
            mState = S_RESET; mHigh = DEPTH - 2; mLow = 2; mBlk = '0;
            mLast = NI - 1; mCounter = 0; mValid = 0; mErr = '0; mReady = 1;
        end else begin
            old = mState;
            anyNE = 0;
            for (int i = 0; i < NI; i++) if (mIn[i].size() != 0) anyNE = 1;
            for (int o = 0; o < NO; o++) if (mOut[o].size() != 0) anyNE = 1;
            mValid = (old == S_IDLE) && req;
            if (mValid) mCounter = mCtr[idx];
            if (old == S_INIT) begin
                mHigh = high_cfg;
                mLow  = (low_cfg >= high_cfg) ? (int'(high_cfg) + 15) % 16 : int'(low_cfg);
                for (int i = 0; i < NI; i++) mIn[i].delete();
                for (int o = 0; o < NO; o++) mOut[o].delete();
                mBlk = '0;
            end
            if (old == S_IDLE || old == S_ACTIVE) begin
                g = -1;
                for (int k = 1; k <= NI; k++) begin
                    c = (mLast + k) % NI;
                    if (g < 0 && mIn[c].size() > 0) begin
                        d = int'(mIn[c][0]) >> (W - DW);
                        if (!mBlk[d] && mOut[d].size() < DEPTH) g = c;
                    end
                end
                for (int i = 0; i < NI; i++) preSize[i] = mIn[i].size();
                for (int o = 0; o < NO; o++) begin
                    if (pop[o]) begin
                        if (mOut[o].size() > 0) mOutData[o] = mOut[o].pop_front();
                        else mErr[NI+o] = 1'b1;
                    end
                end
                if (g >= 0) begin
                    w = mIn[g].pop_front();
                    d = int'(w) >> (W - DW);
                    mOut[d].push_back(w);
                    mCtr[d] = (mCtr[d] + 1) % 128;
                    mLast = g;
                end
                for (int i = 0; i < NI; i++) begin
                    if (push[i]) begin
                        if (preSize[i] < DEPTH || g == i) mIn[i].push_back(in_data[i*W +: W]);
                        else mErr[i] = 1'b1;
                    end
                end
                for (int o = 0; o < NO; o++) begin
                    if (mOut[o].size() >= mHigh) mBlk[o] = 1'b1;
                    else if (mOut[o].size() <= mLow) mBlk[o] = 1'b0;
                end
            end
            if (old == S_RESET) mState = S_INIT;
            else if (init) mState = S_INIT;
            else if (old == S_INIT) mState = S_IDLE;
            else mState = anyNE ? S_ACTIVE : S_IDLE;
        end
    end

    always @(negedge clk) begin : compare
        logic [NO*W-1:0] eData;
        logic [NO-1:0]   eEmpty;
        logic [NI-1:0]   eFull;
        if (mReady) begin
            for (int o = 0; o < NO; o++) begin
                eData[o*W +: W] = mOutData[o];
                eEmpty[o] = (mOut[o].size() == 0);
            end
            for (int i = 0; i < NI; i++) eFull[i] = (mIn[i].size() == DEPTH);
            checkOutput("out_empty", 64'(out_empty), 64'(eEmpty));
            checkOutput("in_full", 64'(in_full), 64'(eFull));
            checkOutput("out_data", 64'(out_data), 64'(eData));
            checkOutput("idle", 64'(idle), 64'(mState == S_IDLE));
            checkOutput("counter", 64'(counter), 64'(mCounter));
            checkOutput("valid_counter", 64'(valid_counter), 64'(mValid));
            checkOutput("err", 64'(err), 64'(mErr));
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset = 1'b0; init = 1'b0; push = '0; pop = '0; req = 1'b0; idx = '0;
        in_data = '0; high_cfg = 4'd6; low_cfg = 4'd2;

        // Reset and init sequence
        applyStimulus(2);
        checkOutput("rst_out_empty", 64'(out_empty), 64'h0F);
        checkOutput("rst_idle", 64'(idle), 64'h0);
        checkOutput("rst_err", 64'(err), 64'h0);
        checkOutput("rst_out_data", 64'(out_data), 64'h0);
        checkOutput("rst_counter", 64'(counter), 64'h0);
        reset = 1'b1; init = 1'b1;
        applyStimulus(3);
        checkOutput("init_idle", 64'(idle), 64'h0);
        init = 1'b0;
        applyStimulus(1);
        checkOutput("init_exit_idle", 64'(idle), 64'h1);

        // Round-robin: one dest-0 word on every input at once
        push = 4'hF;
        in_data = {10'h044, 10'h033, 10'h022, 10'h011};
        applyStimulus(1);
        push = '0;
        for (int k = 1; k <= 4; k++) begin
            applyStimulus(1);
            checkOutput("rr_model_depth", 64'(mOut[0].size()), 64'(k));
        end
        checkOutput("rr_out_empty", 64'(out_empty), 64'h0E);
        for (int k = 0; k < 4; k++) begin
            pop = 4'h1;
            applyStimulus(1);
            checkOutput("rr_order", 64'(out_data[0 +: W]), 64'h011 * (k + 1));
        end
        pop = '0;
        applyStimulus(1);
        req = 1'b1; idx = 2'd0;
        applyStimulus(1);
        req = 1'b0;
        checkOutput("rr_counter", 64'(counter), 64'd4);

        // Routing by head destination
        in_data = '0;
        in_data[0 +: W] = 10'h3A5;
        push = 4'h1;
        applyStimulus(1);
        push = '0;
        applyStimulus(1);
        checkOutput("route_out_empty", 64'(out_empty), 64'h07);
        pop = 4'h8;
        applyStimulus(1);
        pop = '0;
        checkOutput("route_data", 64'(out_data[3*W +: W]), 64'h3A5);
        applyStimulus(1);
        checkOutput("route_idle", 64'(idle), 64'h1);
        req = 1'b1; idx = 2'd3;
        applyStimulus(1);
        req = 1'b0;
        checkOutput("route_counter", 64'(counter), 64'd1);
        checkOutput("route_valid", 64'(valid_counter), 64'd1);
        applyStimulus(1);
        checkOutput("route_valid_drop", 64'(valid_counter), 64'd0);
        checkOutput("route_counter_hold", 64'(counter), 64'd1);

        // Backpressure on out1 with a dest-0 word sneaking past
        push = 4'h4;
        for (int k = 1; k <= 8; k++) begin
            in_data[2*W +: W] = W'(10'h100 + k);
            applyStimulus(1);
        end
        push = 4'h2;
        in_data[1*W +: W] = 10'h055;
        applyStimulus(1);
        push = '0;
        applyStimulus(3);
        checkOutput("bp_out_empty", 64'(out_empty), 64'h0C);
        checkOutput("bp_model_out1", 64'(mOut[1].size()), 64'd6);
        checkOutput("bp_model_in2", 64'(mIn[2].size()), 64'd2);
        for (int k = 0; k < 4; k++) begin
            pop = (k == 0) ? 4'h3 : 4'h2;
            applyStimulus(1);
            checkOutput("bp_pop_out1", 64'(out_data[1*W +: W]), 64'h101 + k);
            if (k == 0) checkOutput("bp_pop_out0", 64'(out_data[0 +: W]), 64'h055);
        end
        pop = '0;
        applyStimulus(2);
        checkOutput("bp_resume_in2", 64'(mIn[2].size()), 64'd0);
        for (int k = 0; k < 4; k++) begin
            pop = 4'h2;
            applyStimulus(1);
            checkOutput("bp_drain_out1", 64'(out_data[1*W +: W]), 64'h105 + k);
        end
        pop = '0;
        applyStimulus(1);

        // Error flags with tight thresholds (low >= high gets clamped)
        init = 1'b1; high_cfg = 4'd2; low_cfg = 4'd5;
        applyStimulus(2);
        init = 1'b0;
        applyStimulus(1);
        checkOutput("err_model_low", 64'(mLow), 64'd1);
        pop = 4'h4;
        applyStimulus(1);
        pop = '0;
        checkOutput("err_underflow", 64'(err), 64'h40);
        push = 4'h2;
        in_data[1*W +: W] = 10'h2A1;
        applyStimulus(1);
        in_data[1*W +: W] = 10'h2A2;
        applyStimulus(1);
        push = '0;
        applyStimulus(2);
        push = 4'h1;
        for (int k = 1; k <= 9; k++) begin
            in_data[0 +: W] = W'(10'h200 + k);
            applyStimulus(1);
        end
        push = '0;
        checkOutput("err_in_full", 64'(in_full), 64'h1);
        checkOutput("err_overflow", 64'(err), 64'h41);
        applyStimulus(3);
        init = 1'b1; high_cfg = 4'd6; low_cfg = 4'd2;
        applyStimulus(2);
        init = 1'b0;
        applyStimulus(1);
        checkOutput("err_sticky_init", 64'(err), 64'h41);
        checkOutput("err_flush_full", 64'(in_full), 64'h0);
        checkOutput("err_flush_empty", 64'(out_empty), 64'h0F);

        // Reset while words are in flight
        push = 4'hF;
        in_data = {10'h3DD, 10'h2CC, 10'h1BB, 10'h0AA};
        applyStimulus(1);
        push = '0;
        applyStimulus(1);
        reset = 1'b0;
        applyStimulus(1);
        reset = 1'b1;
        checkOutput("mid_rst_empty", 64'(out_empty), 64'h0F);
        checkOutput("mid_rst_full", 64'(in_full), 64'h0);
        checkOutput("mid_rst_err", 64'(err), 64'h0);
        checkOutput("mid_rst_data", 64'(out_data), 64'h0);
        applyStimulus(2);
        checkOutput("mid_rst_idle", 64'(idle), 64'h1);
        req = 1'b1; idx = 2'd3;
        applyStimulus(1);
        req = 1'b0;
        checkOutput("mid_rst_ctr3", 64'(counter), 64'd0);
        checkOutput("mid_rst_valid", 64'(valid_counter), 64'd1);
        applyStimulus(2);

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nFail);
        $finish;
    end

endmodule
